// File: rtl/vga_scan_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_scan_timing_pkg : 1024x768@60 raster constants and split-coordinate helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_scan_timing_pkg;

  localparam int X_SPLIT = 32;
  localparam int Y_SPLIT = 48;
  localparam int X_LO_W  = 5;
  localparam int X_HI_W  = 6;
  localparam int Y_LO_W  = 6;
  localparam int Y_HI_W  = 5;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FRONT  = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BACK   = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FRONT  = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BACK   = 29;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Frame-window corners in (hi,lo) form so the pixel stage never needs a multiplier.
  localparam int HSYNC_START_HI = (DEF_H_ACTIVE + DEF_H_FRONT) / X_SPLIT;
  localparam int HSYNC_START_LO = (DEF_H_ACTIVE + DEF_H_FRONT) % X_SPLIT;
  localparam int VBLANK_START_HI = DEF_V_ACTIVE / Y_SPLIT;
  localparam int VBLANK_START_LO = DEF_V_ACTIVE % Y_SPLIT;
  localparam int VSYNC_START_HI = (DEF_V_ACTIVE + DEF_V_FRONT) / Y_SPLIT;
  localparam int VSYNC_START_LO = (DEF_V_ACTIVE + DEF_V_FRONT) % Y_SPLIT;

  function automatic logic split_ge(input int hi, input int lo, input int c_hi, input int c_lo);
    return (hi > c_hi) || ((hi == c_hi) && (lo >= c_lo));
  endfunction

  function automatic logic split_eq(input int hi, input int lo, input int c_hi, input int c_lo);
    return (hi == c_hi) && (lo == c_lo);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_split_counter.sv
// ---------------------------------------------------------------------------
// vga_split_counter : (hi,lo) position counter with programmable terminal pair
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_split_counter #(
  parameter int LO_MOD  = 32,
  parameter int LO_W    = 5,
  parameter int HI_W    = 6,
  parameter int HI_LAST = 41,
  parameter int LO_LAST = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  output logic [LO_W-1:0] lo_o,
  output logic [HI_W-1:0] hi_o,
  output logic [LO_W-1:0] lo_d_o,
  output logic [HI_W-1:0] hi_d_o,
  output logic            wrap_o
);

  logic [LO_W-1:0] lo_q, lo_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic            at_lo_max;
  logic            at_end;

  always_comb begin
    at_lo_max = (lo_q == LO_W'(LO_MOD - 1));
    // Terminal pair need not sit on a lo wrap (e.g. last line y_lo=37).
    at_end    = (hi_q == HI_W'(HI_LAST)) && (lo_q == LO_W'(LO_LAST));
    wrap_o    = inc_i && at_end;
    lo_d      = lo_q;
    hi_d      = hi_q;
    if (inc_i) begin
      if (at_end) begin
        lo_d = '0;
        hi_d = '0;
      end else if (at_lo_max) begin
        lo_d = '0;
        hi_d = hi_q + HI_W'(1);
      end else begin
        lo_d = lo_q + LO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o   = lo_q;
  assign hi_o   = hi_q;
  assign lo_d_o = lo_d;
  assign hi_d_o = hi_d;

endmodule

`default_nettype wire

// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing : raster sync/blank generator with split beam position and vblank irq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_scan_timing
  import vga_scan_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cli,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       interrupt,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi
);

  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int X_HI_LAST = H_TOTAL / X_SPLIT - 1;
  localparam int Y_HI_LAST = (V_TOTAL - 1) / Y_SPLIT;
  localparam int Y_LO_LAST = (V_TOTAL - 1) % Y_SPLIT;
  localparam int HS_START  = H_ACTIVE + H_FRONT;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FRONT;
  localparam int VS_END    = VS_START + V_SYNC;

  logic [X_LO_W-1:0] x_lo_d;
  logic [X_HI_W-1:0] x_hi_d;
  logic [Y_LO_W-1:0] y_lo_d;
  logic [Y_HI_W-1:0] y_hi_d;
  logic              x_wrap;
  logic              y_wrap_unused;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic blank_q, blank_d;
  logic irq_q, irq_d;
  logic hs_act, vs_act, irq_set;
  int   xh, xl, yh, yl;

  vga_split_counter #(
    .LO_MOD (X_SPLIT),
    .LO_W   (X_LO_W),
    .HI_W   (X_HI_W),
    .HI_LAST(X_HI_LAST),
    .LO_LAST(X_SPLIT - 1)
  ) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (1'b1),
    .lo_o  (x_lo),
    .hi_o  (x_hi),
    .lo_d_o(x_lo_d),
    .hi_d_o(x_hi_d),
    .wrap_o(x_wrap)
  );

  vga_split_counter #(
    .LO_MOD (Y_SPLIT),
    .LO_W   (Y_LO_W),
    .HI_W   (Y_HI_W),
    .HI_LAST(Y_HI_LAST),
    .LO_LAST(Y_LO_LAST)
  ) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (x_wrap),
    .lo_o  (y_lo),
    .hi_o  (y_hi),
    .lo_d_o(y_lo_d),
    .hi_d_o(y_hi_d),
    .wrap_o(y_wrap_unused)
  );

  // Decode from next position so registered outputs line up with the counters.
  always_comb begin
    xh = int'(x_hi_d);
    xl = int'(x_lo_d);
    yh = int'(y_hi_d);
    yl = int'(y_lo_d);
    hs_act = split_ge(xh, xl, HS_START / X_SPLIT, HS_START % X_SPLIT) &&
             !split_ge(xh, xl, HS_END / X_SPLIT, HS_END % X_SPLIT);
    vs_act = split_ge(yh, yl, VS_START / Y_SPLIT, VS_START % Y_SPLIT) &&
             !split_ge(yh, yl, VS_END / Y_SPLIT, VS_END % Y_SPLIT);
    blank_d = split_ge(xh, xl, H_ACTIVE / X_SPLIT, H_ACTIVE % X_SPLIT) ||
              split_ge(yh, yl, V_ACTIVE / Y_SPLIT, V_ACTIVE % Y_SPLIT);
    hsync_d = hs_act ^ SYNC_NEG;
    vsync_d = vs_act ^ SYNC_NEG;
    irq_set = x_wrap && split_eq(yh, yl, V_ACTIVE / Y_SPLIT, V_ACTIVE % Y_SPLIT);
    irq_d   = irq_set || (irq_q && !cli);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= SYNC_NEG;
      vsync_q <= SYNC_NEG;
      blank_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      irq_q   <= irq_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign interrupt = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_timing : self-checking bench, small-raster and full 1024x768 instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_scan_timing;

  localparam int S_HA = 64, S_HF = 8, S_HS = 12, S_HB = 12;
  localparam int S_VA = 52, S_VF = 3, S_VS = 4, S_VB = 5;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 96
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 64
  localparam int F_HT = 1344, F_VT = 806;

  logic clk = 1'b0;
  logic rst, cli;
  always #5 clk = ~clk;

  logic       s_hsync, s_vsync, s_blank, s_irq;
  logic [4:0] s_x_lo;
  logic [5:0] s_x_hi;
  logic [5:0] s_y_lo;
  logic [4:0] s_y_hi;
  logic       f_hsync, f_vsync, f_blank, f_irq;
  logic [4:0] f_x_lo;
  logic [5:0] f_x_hi;
  logic [5:0] f_y_lo;
  logic [4:0] f_y_hi;

  vga_scan_timing #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_NEG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cli(cli),
    .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .interrupt(s_irq),
    .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi)
  );

  vga_scan_timing dut_full (
    .clk(clk), .rst(rst), .cli(cli),
    .hsync(f_hsync), .vsync(f_vsync), .blank(f_blank), .interrupt(f_irq),
    .x_lo(f_x_lo), .x_hi(f_x_hi), .y_lo(f_y_lo), .y_hi(f_y_hi)
  );

  logic [25:0] s_act, f_act;
  assign s_act = {s_x_hi, s_x_lo, s_y_hi, s_y_lo, s_hsync, s_vsync, s_blank, s_irq};
  assign f_act = {f_x_hi, f_x_lo, f_y_hi, f_y_lo, f_hsync, f_vsync, f_blank, f_irq};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain binary beam position plus sticky interrupt flag.
  int mx, my, fx, fy;
  bit mirq, firq;

  typedef struct {
    int n;
    int x;
    int y;
    bit hs;
    bit vs;
    bit bl;
    bit irq;
  } vec_t;
  vec_t tbl [15];

  function automatic logic [25:0] vec(int x, int y, bit hs, bit vs, bit bl, bit irq);
    return {6'(x / 32), 5'(x % 32), 5'(y / 48), 6'(y % 48), hs, vs, bl, irq};
  endfunction

  function automatic logic [25:0] model_vec(int x, int y, bit irq, int ha, int hs0, int hs1,
                                            int va, int vs0, int vs1);
    return vec(x, y, !(x >= hs0 && x < hs1), !(y >= vs0 && y < vs1), (x >= ha) || (y >= va), irq);
  endfunction

  function automatic logic [25:0] s_exp();
    return model_vec(mx, my, mirq, S_HA, S_HA + S_HF, S_HA + S_HF + S_HS,
                     S_VA, S_VA + S_VF, S_VA + S_VF + S_VS);
  endfunction

  function automatic logic [25:0] f_exp();
    return model_vec(fx, fy, firq, 1024, 1048, 1184, 768, 771, 777);
  endfunction

  task automatic check(string name, logic [25:0] act, logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual {xh,xl,yh,yl,hs,vs,bl,irq}=%h required %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    mx = 0; my = 0; mirq = 1'b0;
    fx = 0; fy = 0; firq = 1'b0;
  endtask

  task automatic step_all(bit c);
    mx++;
    if (mx == S_HT) begin
      mx = 0;
      my = (my + 1) % S_VT;
    end
    mirq = (mx == 0 && my == S_VA) || (mirq && !c);
    fx++;
    if (fx == F_HT) begin
      fx = 0;
      fy = (fy + 1) % F_VT;
    end
    firq = (fx == 0 && fy == 768) || (firq && !c);
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      step_all(cli);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cli = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,    1,  0,  1, 1, 0, 0};
    tbl[1]  = '{63,   64, 0,  1, 1, 1, 0};
    tbl[2]  = '{8,    72, 0,  0, 1, 1, 0};
    tbl[3]  = '{11,   83, 0,  0, 1, 1, 0};
    tbl[4]  = '{1,    84, 0,  1, 1, 1, 0};
    tbl[5]  = '{11,   95, 0,  1, 1, 1, 0};
    tbl[6]  = '{1,    0,  1,  1, 1, 0, 0};
    tbl[7]  = '{4512, 0,  48, 1, 1, 0, 0};
    tbl[8]  = '{384,  0,  52, 1, 1, 1, 1};
    tbl[9]  = '{1,    1,  52, 1, 1, 1, 1};
    tbl[10] = '{287,  0,  55, 1, 0, 1, 1};
    tbl[11] = '{383,  95, 58, 1, 0, 1, 1};
    tbl[12] = '{1,    0,  59, 1, 1, 1, 1};
    tbl[13] = '{479,  95, 63, 1, 1, 1, 1};
    tbl[14] = '{1,    0,  0,  1, 1, 0, 1};

    rst = 1'b1;
    cli = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    check("reset_small", s_act, vec(0, 0, 1, 1, 0, 0));
    check("reset_full", f_act, vec(0, 0, 1, 1, 0, 0));

    // Small raster, one full frame from reset with cli held low
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_cycles(tbl[i].n);
      check($sformatf("table[%0d]", i), s_act,
            vec(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].irq));
    end

    // cli held across the vblank-entry edge, then a single-cycle clear a frame later
    do_reset();
    run_cycles(4991);
    check("pre_vblank", s_act, vec(95, 51, 1, 1, 1, 0));
    cli = 1'b1;
    run_cycles(1);
    check("race_set_wins", s_act, vec(0, 52, 1, 1, 1, 1));
    run_cycles(1);
    check("race_then_clear", s_act, vec(1, 52, 1, 1, 1, 0));
    cli = 1'b0;
    run_cycles(575);
    check("irq_stays_clear", s_act, vec(0, 58, 1, 0, 1, 0));
    run_cycles(5568);
    check("irq_next_frame", s_act, vec(0, 52, 1, 1, 1, 1));
    run_cycles(576);
    check("irq_sticky", s_act, vec(0, 58, 1, 0, 1, 1));
    cli = 1'b1;
    run_cycles(1);
    check("cli_pulse", s_act, vec(1, 58, 1, 0, 1, 0));
    cli = 1'b0;
    run_cycles(574);
    check("frame_last_pixel", s_act, vec(95, 63, 1, 1, 1, 0));
    run_cycles(1);
    check("frame_wrap", s_act, vec(0, 0, 1, 1, 0, 0));

    // Asynchronous reset in the middle of vsync, with irq pending
    run_cycles(5400);
    check("pre_async_rst", s_act, vec(24, 56, 1, 0, 1, 1));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_small", s_act, vec(0, 0, 1, 1, 0, 0));
    check("async_rst_full", f_act, vec(0, 0, 1, 1, 0, 0));
    #2;
    rst = 1'b0;
    m_reset();
    run_cycles(1);
    check("release_small", s_act, vec(1, 0, 1, 1, 0, 0));
    check("release_full", f_act, vec(1, 0, 1, 1, 0, 0));

    // Full 1024x768 timing over two lines, every cycle against the model
    do_reset();
    for (int i = 0; i < 2800; i++) begin
      run_cycles(1);
      check("full_line", f_act, f_exp());
    end

    // Randomized cli over three small frames
    do_reset();
    for (int i = 0; i < 3 * S_HT * S_VT + 100; i++) begin
      cli = ($urandom_range(0, 199) == 0);
      run_cycles(1);
      check("random", s_act, s_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
